rtc_bus_cycle: RTL

- Parametrised successor to the single-phase RTC strobe generator.
- Runs a complete multiplexed address/data transaction on the RTC parallel bus from one start pulse: address phase, bus gap, then a data phase (write or read).
- Drives CS/WR/RD/AD strobes, the bus output value and its output enable, and captures read data.
- Sits between the RTC controller FSM and the top-level bidirectional bus pad.

---
 rtl/rtc_bus_cycle_if.sv | 32 +++
 rtl/rtc_bus_cycle.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_cycle_if.sv
// RTC parallel-bus transaction interface.
// Groups the controller request side (start/rw/addr/wdata), the pad side
// (bus_in/bus_out/bus_oe) and the RTC strobes. The transaction engine
// uses the slave modport and the requesting logic uses the master modport.
interface rtc_bus_cycle_if #(
    parameter int DW = 8
);
    logic          start;
    logic          rw;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          cs_n;
    logic          wr_n;
    logic          rd_n;
    logic          ad_n;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;

    modport master (
        output start, rw, addr, wdata, bus_in,
        input  bus_out, bus_oe, cs_n, wr_n, rd_n, ad_n, rdata, busy, done
    );

    modport slave (
        input  start, rw, addr, wdata, bus_in,
        output bus_out, bus_oe, cs_n, wr_n, rd_n, ad_n, rdata, busy, done
    );
endinterface

// File: rtl/rtc_bus_cycle.sv
// RTC multiplexed bus transaction engine.
// One start pulse runs: address phase -> bus gap -> data phase (write or
// read) -> one-cycle done. Every output is a flop decoded from the next
// state, so the first transaction cycle already shows the address phase.
// Optional build macro RTC_BUS_SYNC_EN: bus_in passes through a two-flop
// synchroniser and read capture moves two cycles later to compensate.
module rtc_bus_cycle #(
    parameter int DW       = 8,
    parameter int T_PHASE  = 32,
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 15,
    parameter int T_GAP    = 4
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_cycle_if.slave bus
);

    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

    localparam logic [CW-1:0] PH_LAST   = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(T_GAP - 1);
    localparam logic [CW-1:0] WIN_FIRST = CW'(T_SETUP);
    localparam logic [CW-1:0] WIN_LAST  = CW'(T_SETUP + T_STROBE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          rw_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          win_d;
    logic          rd_phase_d;
    logic          cs_n_d;
    logic          wr_n_d;
    logic          rd_n_d;
    logic          ad_n_d;
    logic          oe_d;
    logic [DW-1:0] bus_out_d;
    logic          busy_d;
    logic          done_d;

    logic          cap_en;
    logic [DW-1:0] cap_src;

`ifdef RTC_BUS_SYNC_EN
    localparam logic [CW-1:0] CAP_IDX = CW'(T_SETUP + T_STROBE + 1);

    logic [DW-1:0] bus_in_p0;
    logic [DW-1:0] bus_in_p1;

    // Two-flop synchroniser on the asynchronous pad input
    always_ff @(posedge clk) begin
        bus_in_p0 <= bus.bus_in;
        bus_in_p1 <= bus_in_p0;
    end

    assign cap_src = bus_in_p1;
`else
    localparam logic [CW-1:0] CAP_IDX = WIN_LAST;

    assign cap_src = bus.bus_in;
`endif

    // Read capture happens on a fixed phase index inside a read data phase
    assign cap_en = (state == S_DATA) && rw_q && (cnt == CAP_IDX);

    // State and phase counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and decode of the strobes for the coming cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (cnt == PH_LAST) state_nxt = S_GAP;
                else                cnt_nxt   = cnt + 1'b1;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) state_nxt = S_DATA;
                else                 cnt_nxt   = cnt + 1'b1;
            end
            S_DATA: begin
                if (cnt == PH_LAST) state_nxt = S_DONE;
                else                cnt_nxt   = cnt + 1'b1;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        win_d      = ((state_nxt == S_ADDR) || (state_nxt == S_DATA)) &&
                     (cnt_nxt >= WIN_FIRST) && (cnt_nxt <= WIN_LAST);
        rd_phase_d = (state_nxt == S_DATA) && rw_q;
        cs_n_d     = !win_d;
        wr_n_d     = !(win_d && !rd_phase_d);
        rd_n_d     = !(win_d && rd_phase_d);
        ad_n_d     = (state_nxt != S_ADDR);
        oe_d       = (state_nxt == S_ADDR) || ((state_nxt == S_DATA) && !rw_q);
        busy_d     = (state_nxt != S_IDLE);
        done_d     = (state_nxt == S_DONE);

        // Address is still on the input port on the accepting edge
        bus_out_d  = '0;
        if (state_nxt == S_ADDR)  bus_out_d = (state == S_IDLE) ? bus.addr : addr_q;
        else if (oe_d)            bus_out_d = wdata_q;
    end

    // Request latch, loaded only when a start is accepted
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && bus.start) begin
            rw_q    <= bus.rw;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Registered bus outputs and strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cs_n    <= 1'b1;
            bus.wr_n    <= 1'b1;
            bus.rd_n    <= 1'b1;
            bus.ad_n    <= 1'b1;
            bus.bus_oe  <= 1'b0;
            bus.bus_out <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.cs_n    <= cs_n_d;
            bus.wr_n    <= wr_n_d;
            bus.rd_n    <= rd_n_d;
            bus.ad_n    <= ad_n_d;
            bus.bus_oe  <= oe_d;
            bus.bus_out <= bus_out_d;
            bus.busy    <= busy_d;
            bus.done    <= done_d;
        end
    end

    // Read data register, held until the next read captures
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      bus.rdata <= '0;
        else if (cap_en) bus.rdata <= cap_src;
    end

endmodule
